// File: rtl/scanner_pkg.sv
// Shared scanner definitions: status codes, memory limit and
// the downlink controller state encoding.
package scanner_pkg;

    localparam logic [2:0] SC_LOW_PWR  = 3'd0;
    localparam logic [2:0] SC_STBY     = 3'd1;
    localparam logic [2:0] SC_SCANNING = 3'd2;
    localparam logic [2:0] SC_IDLE     = 3'd3;
    localparam logic [2:0] SC_FLUSHING = 3'd4;

    localparam logic [7:0] MEM_MAX = 8'd100;

    typedef enum logic [1:0] {
        DL_IDLE,
        DL_REQ,
        DL_DRAIN,
        DL_GAP
    } dl_state_t;

    // Returns 1 when B wins a simultaneous request.
    function automatic logic pick_b(
        input logic [7:0] mem_a,
        input logic [7:0] mem_b,
        input logic       last_sel
    );
        logic b;
        unique case (1'b1)
            (mem_b > mem_a): b = 1'b1;
            (mem_b < mem_a): b = 1'b0;
            default:         b = ~last_sel;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/drain_meter.sv
// Tracks the draining scanner's fill level and accumulates
// drained units into a saturating 16-bit total.
module drain_meter
    import scanner_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [7:0]  mem_in,
    output logic [15:0] total_units
);

    logic [7:0]  prev_mem;
    logic [7:0]  delta;
    logic [16:0] sum;

    always_comb begin
        delta = prev_mem - mem_in;
        sum   = {1'b0, total_units} + {9'd0, delta};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_mem    <= '0;
            total_units <= '0;
        end else if (load) begin
            prev_mem <= mem_in;
        end else if (en) begin
            // Rises in fill are not counted, only followed.
            if (mem_in < prev_mem)
                total_units <= sum[16] ? 16'hFFFF : sum[15:0];
            prev_mem <= mem_in;
        end
    end

endmodule

// File: rtl/downlink_ctrl.sv
// Downlink arbiter: grants one scanner a flush, follows its
// drain to completion and totals the units sent.
module downlink_ctrl
    import scanner_pkg::*;
#(
    parameter int REQ_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        link_open,
    input  logic        rdy_flush_a,
    input  logic        rdy_flush_b,
    input  logic [2:0]  state_a,
    input  logic [2:0]  state_b,
    input  logic [7:0]  mem_used_a,
    input  logic [7:0]  mem_used_b,
    output logic        flush_a,
    output logic        flush_b,
    output logic        xfer_busy,
    output logic        xfer_sel,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic [15:0] total_units
);

    localparam int RW = $clog2(REQ_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [RW-1:0] REQ_LAST = RW'(REQ_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    dl_state_t     state, state_n;
    logic          sel_n;
    logic          last_sel, last_sel_n;
    logic [RW-1:0] req_cnt, req_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          fl_n, done_n, err_n;
    logic          load, en;
    logic          elig_a, elig_b, grant;
    logic [2:0]    st_sel;
    logic [7:0]    mem_sel;

    assign elig_a  = link_open & (rdy_flush_a | (state_a == SC_IDLE));
    assign elig_b  = link_open & (rdy_flush_b | (state_b == SC_IDLE));
    assign grant   = (elig_a & elig_b)
                   ? pick_b(mem_used_a, mem_used_b, last_sel)
                   : elig_b;
    assign st_sel  = xfer_sel ? state_b : state_a;
    assign mem_sel = xfer_sel ? mem_used_b : mem_used_a;

    always_comb begin
        state_n    = state;
        sel_n      = xfer_sel;
        last_sel_n = last_sel;
        req_cnt_n  = req_cnt;
        gap_cnt_n  = gap_cnt;
        fl_n       = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        load       = 1'b0;
        en         = 1'b0;
        unique case (state)
            DL_IDLE: begin
                req_cnt_n = '0;
                gap_cnt_n = '0;
                if (elig_a | elig_b) begin
                    state_n = DL_REQ;
                    sel_n   = grant;
                    fl_n    = 1'b1;
                end
            end
            DL_REQ: begin
                if (st_sel == SC_FLUSHING) begin
                    state_n = DL_DRAIN;
                    load    = 1'b1;
                end else if (!link_open) begin
                    state_n = DL_IDLE;
                end else if (req_cnt == REQ_LAST) begin
                    state_n = DL_GAP;
                    err_n   = 1'b1;
                end else begin
                    fl_n      = 1'b1;
                    req_cnt_n = req_cnt + 1'b1;
                end
            end
            DL_DRAIN: begin
                en = 1'b1;
                if (st_sel != SC_FLUSHING) begin
                    state_n    = DL_GAP;
                    done_n     = 1'b1;
                    last_sel_n = xfer_sel;
                end
            end
            DL_GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_n = DL_IDLE;
                else
                    gap_cnt_n = gap_cnt + 1'b1;
            end
            default: state_n = DL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DL_IDLE;
            last_sel  <= 1'b1;
            req_cnt   <= '0;
            gap_cnt   <= '0;
            flush_a   <= 1'b0;
            flush_b   <= 1'b0;
            xfer_busy <= 1'b0;
            xfer_sel  <= 1'b0;
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
        end else begin
            state     <= state_n;
            last_sel  <= last_sel_n;
            req_cnt   <= req_cnt_n;
            gap_cnt   <= gap_cnt_n;
            flush_a   <= fl_n & ~sel_n;
            flush_b   <= fl_n & sel_n;
            xfer_busy <= (state_n != DL_IDLE);
            xfer_sel  <= sel_n;
            xfer_done <= done_n;
            xfer_err  <= err_n;
        end
    end

    drain_meter u_meter (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .en          (en),
        .mem_in      (mem_sel),
        .total_units (total_units)
    );

endmodule

// File: doc/downlink_ctrl.md
# downlink_ctrl

Ground-link controller on the issuing end of the scanner flush handshake. It watches both scanners' status (`rdy_flush`, `mem_used`, `state`) and decides which scanner flushes, and when. It asserts that scanner's `flush` input and tracks the drain to completion. It also accumulates the total data units transferred over the downlink. It sits at top level beside the primary and alternate scanner instances and drives their `flush` inputs.

## Interface
- `REQ_TIMEOUT`, 16: maximum cycles `flush_x` stays asserted without the target reaching flushing.
- `GAP_CYCLES`, 4: quiet cycles after each transfer before a new grant.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `link_open` in 1: ground station visible; new transfers start only while high.
- `rdy_flush_a`, `rdy_flush_b` in 1: scanner A (primary) and B (alternate) ready-to-flush.
- `state_a`, `state_b` in 3: scanner state codes.
- `mem_used_a`, `mem_used_b` in 8: scanner memory fill, 0..100.
- `flush_a`, `flush_b` out 1: flush command to each scanner; never both high.
- `xfer_busy` out 1: high in every state except IDLE.
- `xfer_sel` out 1: scanner of current or last transfer (0 = A, 1 = B).
- `xfer_done` out 1: one-cycle pulse when a drain completes.
- `xfer_err` out 1: one-cycle pulse on request timeout.
- `total_units` out 16: saturating count of units drained.

## Operation
- **Eligibility.** Scanner X is eligible when `link_open` is high and either `rdy_flush_x` is high or `state_x` is IDLE (3'b011).
- **IDLE.**
  - If exactly one scanner is eligible, grant it and go to REQ.
  - If both are eligible, grant the one with the larger `mem_used`.
  - If both are eligible with equal `mem_used`, grant the one not served last. `last_sel` resets to B, so A wins the first tie.
- **REQ.**
  - `flush_sel` is held high.
  - If `state_sel` equals FLUSHING (3'b100), go to DRAIN and load `prev_mem` from `mem_used_sel`.
  - Else if `link_open` falls, drop flush and return to IDLE. No error is raised.
  - Else if the request counter reaches `REQ_TIMEOUT`, pulse `xfer_err` and go to GAP.
- **DRAIN.**
  - Flush is deasserted. The scanner drains on its own and cannot be aborted.
  - Each cycle where `mem_used_sel < prev_mem`, add `(prev_mem − mem_used_sel)` to `total_units`, then update `prev_mem`.
  - Increases in `mem_used_sel` are ignored, but `prev_mem` still tracks them.
  - `link_open` is ignored in this state.
  - When `state_sel` is no longer FLUSHING, pulse `xfer_done`, record `last_sel`, and go to GAP.
- **GAP.** Count `GAP_CYCLES`, then go to IDLE. No grants are made in this state.
- **Saturation.** `total_units` saturates at 16'hFFFF. It does not wrap.
- **Width rules.**
  - The delta is computed 8-bit and zero-extended to 16 bits.
  - The request counter is `$clog2(REQ_TIMEOUT+1)` bits.
  - The gap counter is `$clog2(GAP_CYCLES+1)` bits.

## Timing
- **Reset values.** All outputs are 0, state is IDLE, counters are 0, and `last_sel` = B.
- **Reset mid-operation.** Any asserted flush drops asynchronously. A scanner already flushing completes on its own.
- **Registered outputs.** All outputs are registered.
  - `flush_x` rises 1 cycle after eligibility is sampled in IDLE.
  - The scanner enters flushing on the following edge.
  - REQ sees FLUSHING one edge after that.
  - Minimum REQ dwell is therefore 2 cycles.
- **Drain accounting.** `total_units` reflects each decrement 1 cycle after `mem_used` changes.
- **Completion.** `xfer_done` asserts in the cycle after `state_sel` leaves FLUSHING.
- **Turnaround.** The earliest next `flush` rise is `GAP_CYCLES`+1 cycles after `xfer_done`.
- **Timeout.** `xfer_err` fires on the `REQ_TIMEOUT`-th cycle of REQ. Flush falls on the same edge.
- **Simultaneous eligibility.** Both scanners becoming eligible in the same cycle is resolved by the IDLE arbitration rule above.
- **Unselected scanner.** Its status is ignored outside IDLE.

## Structure
- **Shared package `scanner_pkg`:**
  - scanner state constants: LOW_PWR = 0, STBY = 1, SCANNING = 2, IDLE = 3, FLUSHING = 4;
  - `MEM_MAX` = 100;
  - the `downlink_ctrl` FSM enum (IDLE, REQ, DRAIN, GAP).
- **Sub-module `drain_meter`:**
  - inputs: `clk`, `reset`, `load`, `en`, `mem_in`[7:0];
  - behaviour: tracks `prev_mem` and owns the saturating 16-bit `total_units` accumulator.
- Arbitration and the FSM stay in the top module.

## Test plan
- **Single request.** A: `state` = SCANNING, `mem_used` = 85, `rdy_flush` = 1, `link_open` = 1. Model A enters FLUSHING and drains 1 unit per cycle to 0, then LOW_PWR. Required: `flush_a` high 2 cycles, `total_units` = 85, one `xfer_done`, `xfer_sel` = 0.
- **Arbitration.**
  - A idle at 100, B `rdy_flush` at 90 → A granted first. After the gap B is granted; `total_units` = 190.
  - Repeat with both at 90 → A first, then B.
- **Timeout.** A eligible but the model never enters FLUSHING → `flush_a` high for exactly 16 cycles, one `xfer_err`, `total_units` unchanged, next grant after 4 idle cycles.
- **Link drop.**
  - `link_open` falls during REQ → flush drops the next cycle, return to IDLE, no `xfer_err`.
  - `link_open` falls during DRAIN → drain completes and `xfer_done` fires.
- **Saturation.** Preload via 700 drains of 100 units → `total_units` holds 16'hFFFF.
- **Async reset mid-DRAIN.** `reset` pulsed between edges → all outputs 0 immediately, `last_sel` = B, state IDLE.
